// File: rtl/dw_down_arbiter.sv
// Round-robin arbiter sharing one wide-to-narrow down-converter between NUM_REQ requesters.
// Optional per-requester beat counters are enabled with `define DW_DOWN_ARB_STATS_EN.
module dw_down_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int INPUT_DW   = 512,
    parameter int MAX_BEATS  = 16,
    parameter int ID_W       = $clog2(NUM_REQ),
    parameter int BEAT_CNT_W = $clog2(MAX_BEATS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic [NUM_REQ*INPUT_DW-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [INPUT_DW-1:0]          data_o,
    output logic                         valid_o,
    output logic                         last_o,
    output logic [ID_W-1:0]              id_o,
    input  logic                         ready_i,
    output logic                         busy_o,
    output logic                         split_o
`ifdef DW_DOWN_ARB_STATS_EN
    ,
    input  logic                         stat_clr_i,
    output logic [NUM_REQ*32-1:0]        stat_beats_o
`endif
);

    typedef enum logic {IDLE, LOCKED} state_e;

    localparam logic [BEAT_CNT_W-1:0] CAP_CNT = BEAT_CNT_W'(MAX_BEATS - 1);
    localparam logic [ID_W-1:0]       LAST_ID = ID_W'(NUM_REQ - 1);

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         gnt_q, rr_ptr_q, pick;
    logic                    pick_vld;
    logic [BEAT_CNT_W-1:0]   beat_cnt_q;
    logic                    split_q;
    logic                    sel_valid, sel_last, at_cap, hs, release_hs;
    int                      idx;

    // Scan offsets from high to low so the nearest valid index at/after rr_ptr wins.
    always_comb begin
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        idx      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid_i[idx]) begin
                pick     = ID_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign busy_o     = (state_q == LOCKED);
    assign sel_valid  = req_valid_i[gnt_q];
    assign sel_last   = req_last_i[gnt_q];
    assign at_cap     = (beat_cnt_q == CAP_CNT);
    assign valid_o    = busy_o & sel_valid;
    assign hs         = valid_o & ready_i;
    assign release_hs = hs & (sel_last | at_cap);
    assign last_o     = valid_o & (sel_last | at_cap);
    assign id_o       = busy_o ? gnt_q : '0;
    assign data_o     = busy_o ? req_data_i[int'(gnt_q)*INPUT_DW +: INPUT_DW] : '0;
    assign req_ready_o = (busy_o & ready_i) ? (NUM_REQ'(1) << gnt_q) : '0;
    assign split_o    = split_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = LOCKED;
            LOCKED:  if (release_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            split_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // A cap release only counts as a split when the source did not also end its burst.
            split_q <= release_hs & at_cap & ~sel_last;
            if (state_q == IDLE && pick_vld) begin
                gnt_q      <= pick;
                beat_cnt_q <= '0;
            end else if (hs) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
            if (release_hs) rr_ptr_q <= (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;
        end
    end

`ifdef DW_DOWN_ARB_STATS_EN
    logic [31:0] stat_cnt_q [NUM_REQ];

    // Clear has priority over a handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst_i || stat_clr_i) begin
            for (int r = 0; r < NUM_REQ; r++) stat_cnt_q[r] <= '0;
        end else if (hs) begin
            stat_cnt_q[gnt_q] <= stat_cnt_q[gnt_q] + 32'd1;
        end
    end

    always_comb begin
        stat_beats_o = '0;
        for (int r = 0; r < NUM_REQ; r++) stat_beats_o[r*32 +: 32] = stat_cnt_q[r];
    end
`endif

endmodule

// File: doc/dw_down_arbiter.md
Name: dw_down_arbiter

Overview:
- Round-robin arbiter that shares one wide-to-narrow down-converter between NUM_REQ wide-stream requesters.
- Sits upstream of the down-converter's wide input.
- Locks the grant for a whole burst, which ends on the requester's last flag or on a MAX_BEATS cap.
- Tags the forwarded stream with the requester index so downstream logic can route or account per source.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- INPUT_DW, 512, wide data width per requester and on the output.
- MAX_BEATS, 16, maximum wide beats per grant before forced release (>=1).
- ID_W, $clog2(NUM_REQ), derived; do not override.
- BEAT_CNT_W, $clog2(MAX_BEATS+1), derived; do not override.

Ports:
- clk  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_data_i  in  NUM_REQ*INPUT_DW  requester r data at slice [r*INPUT_DW +: INPUT_DW].
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_last_i  in  NUM_REQ  per-requester end-of-burst flag, qualified by valid.
- req_ready_o  out  NUM_REQ  per-requester ready.
- data_o  out  INPUT_DW  data toward the down-converter.
- valid_o  out  1  output valid.
- last_o  out  1  high on the beat that closes the grant (requester last or cap).
- id_o  out  ID_W  index of the granted requester.
- ready_i  in  1  down-converter ready.
- busy_o  out  1  high while in LOCKED.
- split_o  out  1  one-cycle pulse when a grant is released by the MAX_BEATS cap.

Behaviour:
- Interface: one clock, clk. Reset rst_i is synchronous and active-high; sampled on posedge clk only.
- Reset state:
  - FSM=IDLE, rr_ptr=0, gnt_q=0, beat_cnt=0.
  - All outputs 0: req_ready_o, valid_o, last_o, busy_o, split_o, id_o.
  - Reset asserted mid-burst drops the burst with no completion beat. The next grant restarts from rr_ptr=0.
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any req_valid_i is set, pick the first valid index at or after rr_ptr, searching cyclically.
  - Register that index into gnt_q, clear beat_cnt, go to LOCKED.
  - No data is forwarded in IDLE. Grant latency is 1 cycle from valid to valid_o.
- LOCKED:
  - Forwarding is combinational from the granted requester:
    - data_o = slice gnt_q.
    - valid_o = req_valid_i[gnt_q].
    - req_ready_o = onehot(gnt_q) & ready_i.
    - id_o = gnt_q.
  - Non-granted ready bits are 0.
- Handshake: hs = valid_o & ready_i. On each hs, beat_cnt increments.
- Release condition: hs & (req_last_i[gnt_q] | beat_cnt == MAX_BEATS-1).
  - On release: go to IDLE and set rr_ptr = (gnt_q+1) mod NUM_REQ, wrapping at NUM_REQ-1 to 0.
- last_o = valid_o & (req_last_i[gnt_q] | beat_cnt == MAX_BEATS-1).
- split_o pulses, registered one cycle after release, when release happened with beat_cnt == MAX_BEATS-1 and req_last_i[gnt_q] = 0.
- If the cap and last coincide on the same beat, it is a normal release and split_o stays 0.
- Granted requester drops valid mid-burst: the grant is held; there is no timeout.
- Other requesters' valid changes while LOCKED have no effect.
- Backpressure: while ready_i=0, the selected data and the lock are held and beat_cnt is unchanged.
- Inter-grant bubble: minimum of one IDLE cycle between grants. Full throughput within a grant is 1 beat/cycle.
- busy_o = (state == LOCKED).
- MAX_BEATS=1: every beat releases the grant. split_o pulses for each beat without last.

Optional Feature:
- Macro DW_DOWN_ARB_STATS_EN.
- When defined:
  - Adds output port stat_beats_o, NUM_REQ*32 bits.
  - One free-running 32-bit counter per requester, incremented on each hs of that requester.
  - Counters wrap at 2^32-1 to 0 and are cleared by rst_i.
  - Adds input stat_clr_i (1 bit), which synchronously clears all counters. If stat_clr_i and hs occur in the same cycle, clear wins.
- When undefined: neither port exists and no counters are synthesised. Arbitration behaviour is identical in both builds.

Test Plan:
- Single requester: r2 sends 3 beats, last on the 3rd, ready_i=1.
  - Expect: valid_o from cycle 1 after valid, id_o=2, last_o on beat 3, rr_ptr=3, busy_o low after release.
- All 4 requesters valid continuously, 1-beat bursts each.
  - Expect: grant order 0,1,2,3,0, each separated by one IDLE cycle.
- MAX_BEATS=16, r1 streams 20 beats with no last.
  - Expect: last_o on beat 16, split_o pulse the next cycle, grant moves to another valid requester.
- Backpressure: ready_i toggles 1,0,0,1 during an r0 burst.
  - Expect: data_o and id_o held stable, req_ready_o[0] mirrors ready_i, no beat lost or duplicated.
- Reset mid-burst: assert rst_i on beat 2 of a 5-beat r3 burst.
  - Expect: all outputs 0 next cycle, rr_ptr=0, and the next grant goes to r0 if valid.
- Stats build: 5 hs on r1, then stat_clr_i asserted together with one more hs.
  - Expect: stat_beats_o[r1]=5 before the clear, then 0 after.
